// File: rtl/riscorvo_resp_pkg.sv
// Shared types for the riscorvo bus responder: channel FSM states, request record,
// default MMIO window and the window decode helper.
package riscorvo_resp_pkg;

    typedef enum logic [1:0] {
        RESP_IDLE,
        RESP_WAIT,
        RESP_RESP
    } resp_state_e;

    localparam logic [31:0] DEFAULT_MMIO_BASE = 32'hA000_0000;
    localparam logic [31:0] DEFAULT_MMIO_SIZE = 32'h0000_0014;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic [3:0]  mask;
    } resp_req_t;

    // Subtract first so a window ending at the top of the address space still decodes.
    function automatic logic in_window(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [31:0] size);
        return (addr >= base) && ((addr - base) < size);
    endfunction

endpackage

// File: rtl/riscorvo_bus_responder_if.sv
// Per-channel valid/ready request bus between a core (master) and the responder (slave).
interface riscorvo_bus_responder_if #(
    parameter int NUM_CH = 2
) ();
    import riscorvo_resp_pkg::*;

    logic [NUM_CH-1:0]       valid_i;
    logic [NUM_CH-1:0][31:0] addr_i;
    logic [NUM_CH-1:0][31:0] write_data_i;
    logic [NUM_CH-1:0]       read_write_i;
    logic [NUM_CH-1:0][3:0]  mask_i;
    logic [NUM_CH-1:0]       stall_req_i;
    logic [NUM_CH-1:0]       ready_o;
    logic [NUM_CH-1:0][31:0] read_data_o;

    modport master (
        output valid_i, addr_i, write_data_i, read_write_i, mask_i, stall_req_i,
        input  ready_o, read_data_o
    );

    modport slave (
        input  valid_i, addr_i, write_data_i, read_write_i, mask_i, stall_req_i,
        output ready_o, read_data_o
    );

endinterface

// File: rtl/riscorvo_resp_channel.sv
// One responder channel: IDLE/WAIT/RESP FSM, request latch, MMIO decode and handshake checker.
// RISCORVO_RESP_FAIRNESS_EN adds the wait counter that caps consecutive stall cycles at MAX_WAIT.
module riscorvo_resp_channel
    import riscorvo_resp_pkg::*;
#(
    parameter int          MEM_WORDS = 256,
    parameter int          MAX_WAIT  = 3,
    parameter logic [31:0] MMIO_BASE = DEFAULT_MMIO_BASE,
    parameter logic [31:0] MMIO_SIZE = DEFAULT_MMIO_SIZE,
    localparam int         AW        = $clog2(MEM_WORDS)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          valid_i,
    input  logic          stall_req_i,
    input  resp_req_t     req_i,
    output logic          ready_o,
    output logic          rd_en_o,
    output logic          wr_en_o,
    output logic [AW-1:0] word_o,
    output logic [31:0]   wdata_o,
    output logic [3:0]    mask_o,
    output logic          mmio_hit_o,
    output logic          viol_o
);

    resp_state_e state_q, state_d;
    resp_req_t   req_q, req_d;
    logic        mmio_q, mmio_d;
    logic        wait_done;

`ifdef RISCORVO_RESP_FAIRNESS_EN
    localparam int CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = '0;
        if (state_d == RESP_WAIT) begin
            cnt_d = (state_q == RESP_WAIT) ? cnt_q + CW'(1) : CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign wait_done = (cnt_q == CW'(MAX_WAIT));
`else
    assign wait_done = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        mmio_d     = mmio_q;
        mmio_hit_o = 1'b0;
        viol_o     = 1'b0;
        case (state_q)
            RESP_IDLE: begin
                if (valid_i) begin
                    req_d      = req_i;
                    mmio_d     = in_window(req_i.addr, MMIO_BASE, MMIO_SIZE);
                    mmio_hit_o = mmio_d;
                    state_d    = (stall_req_i && (MAX_WAIT > 0)) ? RESP_WAIT : RESP_RESP;
                end
            end
            RESP_WAIT: begin
                if (!stall_req_i || wait_done) state_d = RESP_RESP;
            end
            RESP_RESP: state_d = RESP_IDLE;
            default:   state_d = RESP_IDLE;
        endcase
        // The core must hold the request unchanged until the response strobe.
        if (state_q != RESP_IDLE) begin
            viol_o = !valid_i || (req_i != req_q);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RESP_IDLE;
            req_q   <= '0;
            mmio_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            mmio_q  <= mmio_d;
        end
    end

    assign ready_o = (state_q == RESP_RESP);
    assign rd_en_o = ready_o && !mmio_q;
    assign wr_en_o = rd_en_o && req_q.we;
    assign word_o  = req_q.addr[AW+1:2];
    assign wdata_o = req_q.wdata;
    assign mask_o  = req_q.mask;

endmodule

// File: rtl/riscorvo_bus_responder.sv
// Memory-side responder serving NUM_CH independent channels from one shared word memory.
// Optional stall bound: define RISCORVO_RESP_FAIRNESS_EN.
module riscorvo_bus_responder
    import riscorvo_resp_pkg::*;
#(
    parameter int          NUM_CH    = 2,
    parameter int          MEM_WORDS = 256,
    parameter int          MAX_WAIT  = 3,
    parameter logic [31:0] MMIO_BASE = DEFAULT_MMIO_BASE,
    parameter logic [31:0] MMIO_SIZE = DEFAULT_MMIO_SIZE
) (
    input  logic                       clk,
    input  logic                       reset_n,
    riscorvo_bus_responder_if.slave    bus,
    output logic                       mmio_hit_o,
    output logic                       violation_o
);

    localparam int AW = $clog2(MEM_WORDS);

    logic [31:0] mem [MEM_WORDS];

    logic [NUM_CH-1:0]          rd_en;
    logic [NUM_CH-1:0]          wr_en;
    logic [NUM_CH-1:0][AW-1:0]  word;
    logic [NUM_CH-1:0][31:0]    wdata;
    logic [NUM_CH-1:0][3:0]     mask;
    logic [NUM_CH-1:0]          ch_mmio;
    logic [NUM_CH-1:0]          ch_viol;
    logic                       mmio_hit_q, mmio_hit_d;
    logic                       viol_q, viol_d;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        resp_req_t req_in;
        assign req_in = '{addr:  bus.addr_i[gi],
                          wdata: bus.write_data_i[gi],
                          we:    bus.read_write_i[gi],
                          mask:  bus.mask_i[gi]};

        riscorvo_resp_channel #(
            .MEM_WORDS (MEM_WORDS),
            .MAX_WAIT  (MAX_WAIT),
            .MMIO_BASE (MMIO_BASE),
            .MMIO_SIZE (MMIO_SIZE)
        ) u_ch (
            .clk         (clk),
            .reset_n     (reset_n),
            .valid_i     (bus.valid_i[gi]),
            .stall_req_i (bus.stall_req_i[gi]),
            .req_i       (req_in),
            .ready_o     (bus.ready_o[gi]),
            .rd_en_o     (rd_en[gi]),
            .wr_en_o     (wr_en[gi]),
            .word_o      (word[gi]),
            .wdata_o     (wdata[gi]),
            .mask_o      (mask[gi]),
            .mmio_hit_o  (ch_mmio[gi]),
            .viol_o      (ch_viol[gi])
        );

        // Reads see memory before this cycle's writes land, so concurrent writers never leak through.
        assign bus.read_data_o[gi] = rd_en[gi] ? mem[word[gi]] : 32'h0;
    end

    // Highest channel applied first so the lowest index overrides it lane by lane.
    always_ff @(posedge clk) begin
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (wr_en[c]) begin
                for (int b = 0; b < 4; b++) begin
                    if (mask[c][b]) mem[word[c]][b*8 +: 8] <= wdata[c][b*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        mmio_hit_d = mmio_hit_q | (|ch_mmio);
        viol_d     = viol_q | (|ch_viol);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mmio_hit_q <= 1'b0;
            viol_q     <= 1'b0;
        end else begin
            mmio_hit_q <= mmio_hit_d;
            viol_q     <= viol_d;
        end
    end

    assign mmio_hit_o  = mmio_hit_q;
    assign violation_o = viol_q;

endmodule

// File: tb/tb_riscorvo_bus_responder.sv
// Directed self-checking bench for riscorvo_bus_responder (both RISCORVO_RESP_FAIRNESS_EN builds).
module tb_riscorvo_bus_responder;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic mmio_hit;
    logic viol;
    int   n_cmp = 0;
    int   n_err = 0;

    riscorvo_bus_responder_if #(.NUM_CH(2)) bus ();

    riscorvo_bus_responder #(
        .NUM_CH    (2),
        .MEM_WORDS (256),
        .MAX_WAIT  (3),
        .MMIO_BASE (32'hA000_0000),
        .MMIO_SIZE (32'h14)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus),
        .mmio_hit_o  (mmio_hit),
        .violation_o (viol)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %-28s observed %h expected %h", tag, obs, exp);
    endtask

    task automatic drive(input int ch, input logic [31:0] a, input logic [31:0] d,
                         input logic we, input logic [3:0] m);
        bus.valid_i[ch]      = 1'b1;
        bus.addr_i[ch]       = a;
        bus.write_data_i[ch] = d;
        bus.read_write_i[ch] = we;
        bus.mask_i[ch]       = m;
    endtask

    // Issue one request, wait (bounded) for ready, check latency and optionally read data.
    task automatic xfer(input string tag, input int ch, input logic [31:0] a, input logic [31:0] d,
                        input logic we, input logic [3:0] m, input int exp_lat,
                        input logic chk_rd, input logic [31:0] exp_rd);
        int   lat;
        logic got;
        logic [31:0] rd;
        lat = 0;
        got = 1'b0;
        rd  = 32'h0;
        drive(ch, a, d, we, m);
        while (!got && lat < 20) begin
            tick();
            lat++;
            if (bus.ready_o[ch]) begin
                got = 1'b1;
                rd  = bus.read_data_o[ch];
            end
        end
        check({tag, " lat"}, lat, exp_lat);
        if (chk_rd) check({tag, " rdata"}, rd, exp_rd);
        tick();
        bus.valid_i[ch] = 1'b0;
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        logic any_ready;
        bus.valid_i      = '0;
        bus.addr_i       = '0;
        bus.write_data_i = '0;
        bus.read_write_i = '0;
        bus.mask_i       = '0;
        bus.stall_req_i  = '0;
        #1;
        check("reset ready", bus.ready_o, 2'b00);
        check("reset rdata0", bus.read_data_o[0], 32'h0);
        check("reset rdata1", bus.read_data_o[1], 32'h0);
        check("reset mmio", mmio_hit, 1'b0);
        check("reset viol", viol, 1'b0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // Basic write/read and shared memory.
        xfer("wr 0x10 ch1", 1, 32'h10, 32'hDEADBEEF, 1'b1, 4'hF, 1, 1'b0, 32'h0);
        xfer("rd 0x10 ch1", 1, 32'h10, 32'h0, 1'b0, 4'h0, 1, 1'b1, 32'hDEADBEEF);
        xfer("rd 0x10 ch0", 0, 32'h10, 32'h0, 1'b0, 4'h0, 1, 1'b1, 32'hDEADBEEF);
        xfer("wr mask 0101", 0, 32'h10, 32'h00AA00CC, 1'b1, 4'b0101, 1, 1'b0, 32'h0);
        xfer("rd after mask", 0, 32'h10, 32'h0, 1'b0, 4'h0, 1, 1'b1, 32'hDEAABECC);
        xfer("rd wrap 0x410", 1, 32'h410, 32'h0, 1'b0, 4'h0, 1, 1'b1, 32'hDEAABECC);

        // Stall held high.
        bus.stall_req_i[0] = 1'b1;
`ifdef RISCORVO_RESP_FAIRNESS_EN
        xfer("stall bounded", 0, 32'h10, 32'h0, 1'b0, 4'h0, 4, 1'b1, 32'hDEAABECC);
        bus.stall_req_i[0] = 1'b0;
`else
        drive(0, 32'h10, 32'h0, 1'b0, 4'h0);
        any_ready = 1'b0;
        repeat (8) begin
            tick();
            any_ready = any_ready | bus.ready_o[0];
        end
        check("stall unbounded no ready", any_ready, 1'b0);
        bus.stall_req_i[0] = 1'b0;
        tick();
        check("stall release ready", bus.ready_o[0], 1'b1);
        check("stall release rdata", bus.read_data_o[0], 32'hDEAABECC);
        tick();
        bus.valid_i[0] = 1'b0;
`endif
        check("no viol after traffic", viol, 1'b0);

        // MMIO window and its upper boundary.
        xfer("wr 0xA0000014", 1, 32'hA000_0014, 32'h0BADF00D, 1'b1, 4'hF, 1, 1'b0, 32'h0);
        xfer("rd 0x14", 1, 32'h14, 32'h0, 1'b0, 4'h0, 1, 1'b1, 32'h0BADF00D);
        check("mmio boundary clear", mmio_hit, 1'b0);
        xfer("wr 0x8", 0, 32'h8, 32'h12345678, 1'b1, 4'hF, 1, 1'b0, 32'h0);
        xfer("rd mmio 0xA0000008", 0, 32'hA000_0008, 32'h0, 1'b0, 4'h0, 1, 1'b1, 32'h0);
        check("mmio hit set", mmio_hit, 1'b1);
        xfer("wr mmio 0x55", 1, 32'hA000_0008, 32'h55, 1'b1, 4'hF, 1, 1'b0, 32'h0);
        xfer("rd 0x8 unchanged", 1, 32'h8, 32'h0, 1'b0, 4'h0, 1, 1'b1, 32'h12345678);

        // Simultaneous writes: lowest channel wins per lane.
        drive(0, 32'h40, 32'h11111111, 1'b1, 4'hF);
        drive(1, 32'h40, 32'h22222222, 1'b1, 4'hF);
        tick();
        check("dual wr ready", bus.ready_o, 2'b11);
        tick();
        bus.valid_i = '0;
        xfer("rd 0x40 prio", 1, 32'h40, 32'h0, 1'b0, 4'h0, 1, 1'b1, 32'h11111111);
        drive(0, 32'h44, 32'hAAAAAAAA, 1'b1, 4'b0011);
        drive(1, 32'h44, 32'hBBBBBBBB, 1'b1, 4'b1110);
        tick();
        tick();
        bus.valid_i = '0;
        xfer("rd 0x44 lanes", 0, 32'h44, 32'h0, 1'b0, 4'h0, 1, 1'b1, 32'hBBBBAAAA);

        // Read concurrent with another channel's write returns the old word.
        drive(0, 32'h40, 32'h0, 1'b0, 4'h0);
        drive(1, 32'h40, 32'h33333333, 1'b1, 4'hF);
        tick();
        check("concurrent rd old", bus.read_data_o[0], 32'h11111111);
        tick();
        bus.valid_i = '0;
        xfer("rd 0x40 new", 0, 32'h40, 32'h0, 1'b0, 4'h0, 1, 1'b1, 32'h33333333);

        // Reset during RESP aborts the pending write.
        xfer("wr 0x20 old", 1, 32'h20, 32'hCAFEF00D, 1'b1, 4'hF, 1, 1'b0, 32'h0);
        drive(1, 32'h20, 32'h99999999, 1'b1, 4'hF);
        tick();
        check("pre-reset ready", bus.ready_o[1], 1'b1);
        #1 reset_n = 1'b0;
        #1;
        check("async reset ready", bus.ready_o[1], 1'b0);
        check("async reset rdata", bus.read_data_o[1], 32'h0);
        check("async reset mmio", mmio_hit, 1'b0);
        bus.valid_i = '0;
        tick();
        reset_n = 1'b1;
        tick();
        xfer("rd 0x20 kept", 1, 32'h20, 32'h0, 1'b0, 4'h0, 1, 1'b1, 32'hCAFEF00D);

        // valid dropped during WAIT.
        bus.stall_req_i[0] = 1'b1;
        drive(0, 32'h10, 32'h0, 1'b0, 4'h0);
        tick();
        check("wait no ready", bus.ready_o[0], 1'b0);
        check("wait no viol", viol, 1'b0);
        bus.valid_i[0] = 1'b0;
        tick();
        check("viol valid drop", viol, 1'b1);
        bus.stall_req_i[0] = 1'b0;
        repeat (3) tick();
        check("viol held", viol, 1'b1);
        pulse_reset();
        check("viol cleared", viol, 1'b0);

        // Address changed during WAIT.
        bus.stall_req_i[0] = 1'b1;
        drive(0, 32'h10, 32'h0, 1'b0, 4'h0);
        tick();
        bus.addr_i[0] = 32'h14;
        tick();
        check("viol addr change", viol, 1'b1);
        bus.stall_req_i[0] = 1'b0;
        bus.valid_i[0] = 1'b0;
        repeat (3) tick();
        check("viol addr held", viol, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/riscorvo_bus_responder.md
# riscorvo_bus_responder

Parametrised memory-side responder for the riscorvo valid/ready instruction and data buses, used as the environment model in formal and simulation benches. It serves NUM_CH independent request channels from one shared word-addressed memory, injects externally chosen stalls with a hard upper bound on consecutive wait cycles, and blanks a configurable MMIO window. It also flags handshake protocol violations by the core.

## Interface
Parameters:
- NUM_CH, 2, number of request channels; channel 0 is instruction, channel 1 is data.
- MEM_WORDS, 256, depth of the shared 32-bit memory; power of two.
- MAX_WAIT, 3, maximum consecutive stall cycles per request; 0 means no stall is ever applied.
- MMIO_BASE, 32'hA000_0000, base address of the blanked MMIO window.
- MMIO_SIZE, 32'h14, byte size of the MMIO window.

Ports:
- clk  in  1  single clock.
- reset_n  in  1  asynchronous, active-low reset.
- valid_i  in  NUM_CH  per-channel request valid.
- addr_i  in  NUM_CH×32  byte address.
- write_data_i  in  NUM_CH×32  write data.
- read_write_i  in  NUM_CH  1 = write, 0 = read.
- mask_i  in  NUM_CH×4  byte enables for writes.
- stall_req_i  in  NUM_CH  stall request from the bench or formal free variable.
- ready_o  out  NUM_CH  one-cycle response strobe.
- read_data_o  out  NUM_CH×32  read data, valid while ready_o is high.
- mmio_hit_o  out  1  sticky flag: some request targeted the MMIO window.
- violation_o  out  1  sticky flag: handshake protocol violation.

## Operation
- Each channel runs a three-state FSM.
  - IDLE to RESP on valid_i with stall_req_i low.
  - IDLE to WAIT on valid_i with stall_req_i high and MAX_WAIT > 0. The wait counter loads 1, and the address and control fields are latched.
  - WAIT to RESP when stall_req_i is low or the counter equals MAX_WAIT. Otherwise the counter increments.
  - RESP always returns to IDLE.
- ready_o is asserted only in RESP. read_data_o is mem[addr[log2(MEM_WORDS)+1:2]]. Addresses wrap modulo MEM_WORDS×4. A write commits at the RESP clock edge under mask_i.
- MMIO hit (MMIO_BASE ≤ addr < MMIO_BASE+MMIO_SIZE): the read returns 32'h0, the write is dropped, and mmio_hit_o is set.
- Protocol checker, per channel, in WAIT or RESP:
  - valid_i low sets violation_o.
  - addr_i, read_write_i, write_data_i or mask_i differing from the latched values sets violation_o.
- Simultaneous writes from two channels to the same word: the lowest channel index wins, per byte lane.
- A read in RESP concurrent with another channel's write to the same word returns the old value.
- The memory is not reset. Contents of never-written words are unspecified.

## Timing
- Reset, asynchronous: all FSMs go to IDLE, counters 0, ready_o 0, read_data_o 0, mmio_hit_o 0, violation_o 0. Reset asserted mid-WAIT or mid-RESP aborts the request; a pending write is not committed.
- Minimum latency: valid_i sampled high at edge t gives ready_o high during cycle t+1.
- Worst-case latency is MAX_WAIT+1 cycles.
- Back-to-back requests incur one IDLE bubble. With valid_i held after ready_o, the next ready_o comes at the earliest 2 cycles later.
- Channels are fully independent. There is no arbitration stall.

## Configuration
- RISCORVO_RESP_FAIRNESS_EN:
  - Defined: the MAX_WAIT bound is enforced as above.
  - Undefined: the wait counter is removed and WAIT exits only when stall_req_i is low, so unbounded stalls are possible. MAX_WAIT is then ignored, except that 0 still disables stalls.

## Structure
- Package riscorvo_resp_pkg: FSM state enum (RESP_IDLE, RESP_WAIT, RESP_RESP), default MMIO_BASE/MMIO_SIZE constants, and a request struct (addr, wdata, we, mask).
- Sub-module riscorvo_resp_channel contains the per-channel FSM, wait counter, latch, checker and MMIO decode. It is generated NUM_CH times.
- The top level owns the memory array and the write-priority merge.

## Test plan
- Channel 1 write 0xDEADBEEF to 0x10 with mask 4'hF, then a read of 0x10 with stall_req_i low → ready_o one cycle after each valid_i, read_data_o 0xDEADBEEF.
- stall_req_i held high, MAX_WAIT=3, FAIRNESS_EN defined → ready_o exactly 4 cycles after valid_i. With FAIRNESS_EN undefined → no ready_o until stall_req_i drops.
- Read of 0xA000_0008 → read_data_o 0, mmio_hit_o set. A write of 0x55 there leaves the memory unchanged.
- Both channels write 0x11111111 and 0x22222222 to 0x40 with mask 4'hF in the same RESP cycle → a later read returns 0x11111111.
- valid_i dropped during WAIT, or addr_i changed during WAIT → violation_o set on the next edge and held.
- reset_n pulsed low while channel 1 is in RESP with a write to 0x20 → ready_o 0 immediately, and the word at 0x20 retains its old value.
